// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, write-back source selects and load funct3 encodings
package riscv_pkg;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/load_extract.sv
// load_extract: lane shift, sign/zero extension and misalignment check for loads
module load_extract #(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_funct3,
  input  logic [2:0]      i_off,
  input  logic [XLEN-1:0] i_mem_data,
  output logic [XLEN-1:0] o_data,
  output logic            o_misaligned
);
  logic [XLEN-1:0] w_lane;
  logic            w_sx;
  assign w_lane = i_mem_data >> {i_off, 3'b000};
  assign w_sx   = ~i_funct3[2];
  // funct3[1:0] is the access size; funct3[2] selects zero-extension (111 behaves as LD)
  always_comb begin
    o_data = (i_funct3[1:0] == 2'b00) ? {{(XLEN-8){w_sx & w_lane[7]}}, w_lane[7:0]} :
             (i_funct3[1:0] == 2'b01) ? {{(XLEN-16){w_sx & w_lane[15]}}, w_lane[15:0]} :
             (i_funct3[1:0] == 2'b10) ? {{(XLEN-32){w_sx & w_lane[31]}}, w_lane[31:0]} :
             w_lane;
    o_misaligned = (i_funct3[1:0] == 2'b01) ? i_off[0] :
                   (i_funct3[1:0] == 2'b10) ? |i_off[1:0] :
                   (i_funct3[1:0] == 2'b11) ? |i_off :
                   1'b0;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: registers memory results, extracts loads, drives RF write port and retire strobe; WB_INSTRET_EN adds a retire counter
module writeback_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_funct3,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_mem_data,
  input  logic [XLEN-1:0]   in_pc,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              exc_misaligned,
  output logic [XLEN-1:0]   exc_addr,
  output logic              retired
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);
  import riscv_pkg::*;
  logic            w_accept;
  logic            w_load;
  logic            w_ld_mis;
  logic            w_mis;
  logic            w_we;
  logic [XLEN-1:0] w_ld_data;
  logic [XLEN-1:0] w_wdata;
  load_extract #(.XLEN(XLEN)) u_load_extract (
    .i_funct3     (in_funct3),
    .i_off        (in_alu_result[2:0]),
    .i_mem_data   (in_mem_data),
    .o_data       (w_ld_data),
    .o_misaligned (w_ld_mis)
  );
  assign in_ready = ~stall;
  assign w_accept = in_valid & ~stall & ~flush;
  assign w_load   = in_wb_sel == WB_SEL_MEM;
  assign w_mis    = w_load & w_ld_mis;
  assign w_we     = w_accept & in_reg_write & (|in_rd) & ~w_mis;
  assign w_wdata  = w_load ? w_ld_data :
                    (in_wb_sel == WB_SEL_PC4) ? in_pc + XLEN'(4) :
                    in_alu_result;
  // strobes fire only on accept; address/data hold unless an instruction completes
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      exc_misaligned <= 1'b0;
      exc_addr       <= '0;
      retired        <= 1'b0;
    end else begin
      rf_we          <= w_we;
      retired        <= w_accept & ~w_mis;
      exc_misaligned <= w_accept & w_mis;
      if (w_accept & ~w_mis) begin
        rf_waddr <= in_rd;
        rf_wdata <= w_wdata;
      end
      if (w_accept & w_mis) exc_addr <= in_alu_result;
    end
  end
`ifdef WB_INSTRET_EN
  // counts retire pulses and traces each register write
  always_ff @(posedge clk) begin
    if (reset) instret <= '0;
    else if (retired) instret <= instret + 64'd1;
    if (!reset && w_we) $display("writeback: x%0d <= 0x%h", in_rd, w_wdata);
  end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table-driven scoreboard bench for writeback_stage
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [63:0] in_alu_result, in_mem_data, in_pc;
  logic        in_ready, rf_we, exc_misaligned, retired;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata, exc_addr;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif
  int passed = 0;
  int total  = 0;
  int writes;
  typedef struct {
    logic rst, valid, stall, flush, rw;
    logic [1:0] sel;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [63:0] alu, mem, pc;
    logic e_we;
    logic [4:0] e_wa;
    logic [63:0] e_wd;
    logic e_exc;
    logic [63:0] e_ea;
    logic e_ret;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];

  writeback_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc(in_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exc_misaligned(exc_misaligned), .exc_addr(exc_addr), .retired(retired)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, valid, stl, fl, rw, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [4:0] rd,
                              input logic [63:0] alu, mem, pc, input logic e_we,
                              input logic [4:0] e_wa, input logic [63:0] e_wd,
                              input logic e_exc, input logic [63:0] e_ea, input logic e_ret);
    vec_t v;
    v.rst = rst; v.valid = valid; v.stall = stl; v.flush = fl; v.rw = rw;
    v.sel = sel; v.f3 = f3; v.rd = rd; v.alu = alu; v.mem = mem; v.pc = pc;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_exc = e_exc; v.e_ea = e_ea; v.e_ret = e_ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    reset = v.rst; in_valid = v.valid; stall = v.stall; flush = v.flush;
    in_reg_write = v.rw; in_wb_sel = v.sel; in_funct3 = v.f3; in_rd = v.rd;
    in_alu_result = v.alu; in_mem_data = v.mem; in_pc = v.pc;
    sb.push_back(v);
    #1 chk({tag, " in_ready"}, {63'd0, in_ready}, {63'd0, ~v.stall});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " rf_we"}, {63'd0, rf_we}, {63'd0, e.e_we});
    chk({tag, " rf_waddr"}, {59'd0, rf_waddr}, {59'd0, e.e_wa});
    chk({tag, " rf_wdata"}, rf_wdata, e.e_wd);
    chk({tag, " exc_misaligned"}, {63'd0, exc_misaligned}, {63'd0, e.e_exc});
    chk({tag, " exc_addr"}, exc_addr, e.e_ea);
    chk({tag, " retired"}, {63'd0, retired}, {63'd0, e.e_ret});
    if (rf_we) writes++;
  endtask

  initial begin
    //         rst v st fl rw sel    f3      rd  alu                     mem                     pc                      we wa  wdata                   exc ea            ret
    tbl.push_back(mk(1,0,0,0,0,2'b00,3'b000,5'd0, 64'h0,                 64'h0,                  64'h0,                  0,5'd0, 64'h0,                  0,64'h0,     0));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b000,5'd5, 64'h1003,              64'h0000_0000_80FF_0000,64'h0,                  1,5'd5, 64'hFFFF_FFFF_FFFF_FF80,0,64'h0,     1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b000,5'd6, 64'h1002,              64'h0000_0000_80FF_0000,64'h0,                  1,5'd6, 64'hFFFF_FFFF_FFFF_FFFF,0,64'h0,     1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b101,5'd7, 64'h1006,              64'hBEEF_0000_0000_0000,64'h0,                  1,5'd7, 64'h0000_0000_0000_BEEF,0,64'h0,     1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b001,5'd8, 64'h1006,              64'hBEEF_0000_0000_0000,64'h0,                  1,5'd8, 64'hFFFF_FFFF_FFFF_BEEF,0,64'h0,     1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b010,5'd9, 64'h1002,              64'h1234_5678_9ABC_DEF0,64'h0,                  0,5'd8, 64'hFFFF_FFFF_FFFF_BEEF,1,64'h1002,  0));
    tbl.push_back(mk(0,0,0,0,1,2'b00,3'b000,5'd9, 64'h55,                64'h0,                  64'h0,                  0,5'd8, 64'hFFFF_FFFF_FFFF_BEEF,0,64'h1002,  0));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b110,5'd10,64'h1004,              64'h89AB_CDEF_0123_4567,64'h0,                  1,5'd10,64'h0000_0000_89AB_CDEF,0,64'h1002,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b010,5'd11,64'h1004,              64'h89AB_CDEF_0123_4567,64'h0,                  1,5'd11,64'hFFFF_FFFF_89AB_CDEF,0,64'h1002,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b011,5'd12,64'h1000,              64'h0123_4567_89AB_CDEF,64'h0,                  1,5'd12,64'h0123_4567_89AB_CDEF,0,64'h1002,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b011,5'd13,64'h1004,              64'h0123_4567_89AB_CDEF,64'h0,                  0,5'd12,64'h0123_4567_89AB_CDEF,1,64'h1004,  0));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b111,5'd14,64'h1008,              64'hDEAD_BEEF_CAFE_F00D,64'h0,                  1,5'd14,64'hDEAD_BEEF_CAFE_F00D,0,64'h1004,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b10,3'b000,5'd1, 64'h55,                64'h0,                  64'h400,                1,5'd1, 64'h404,                0,64'h1004,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b10,3'b000,5'd0, 64'h55,                64'h0,                  64'h400,                0,5'd0, 64'h404,                0,64'h1004,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b00,3'b011,5'd3, 64'h1234,              64'h0,                  64'h0,                  1,5'd3, 64'h1234,               0,64'h1004,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b11,3'b001,5'd4, 64'hABCD,              64'h0,                  64'h0,                  1,5'd4, 64'hABCD,               0,64'h1004,  1));
    tbl.push_back(mk(0,1,0,0,0,2'b00,3'b000,5'd5, 64'h77,                64'h0,                  64'h0,                  0,5'd5, 64'h77,                 0,64'h1004,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b10,3'b000,5'd2, 64'h0,                 64'h0,                  64'hFFFF_FFFF_FFFF_FFFC,1,5'd2, 64'h0,                  0,64'h1004,  1));
    tbl.push_back(mk(0,1,0,1,1,2'b00,3'b000,5'd9, 64'h99,                64'h0,                  64'h0,                  0,5'd2, 64'h0,                  0,64'h1004,  0));
    tbl.push_back(mk(0,1,1,0,1,2'b00,3'b000,5'd9, 64'h99,                64'h0,                  64'h0,                  0,5'd2, 64'h0,                  0,64'h1004,  0));
    tbl.push_back(mk(0,1,1,1,1,2'b00,3'b000,5'd9, 64'h99,                64'h0,                  64'h0,                  0,5'd2, 64'h0,                  0,64'h1004,  0));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b001,5'd9, 64'h1001,              64'h0,                  64'h0,                  0,5'd2, 64'h0,                  1,64'h1001,  0));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b000,5'd15,64'h1007,              64'h7F00_0000_0000_0000,64'h0,                  1,5'd15,64'h7F,                 0,64'h1001,  1));
    tbl.push_back(mk(0,1,0,0,1,2'b01,3'b101,5'd16,64'h1003,              64'h0,                  64'h0,                  0,5'd15,64'h7F,                 1,64'h1003,  0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    writes = 0;
    for (int i = 0; i < 3; i++)
      step(mk(0,1,1,0,1,2'b00,3'b000,5'd20,64'hAA,64'h0,64'h0, 0,5'd15,64'h7F,0,64'h1003,0), "stall");
    step(mk(0,1,0,0,1,2'b00,3'b000,5'd20,64'hAA,64'h0,64'h0, 1,5'd20,64'hAA,0,64'h1003,1), "release");
    step(mk(0,0,0,0,1,2'b00,3'b000,5'd20,64'hAA,64'h0,64'h0, 0,5'd20,64'hAA,0,64'h1003,0), "after_release");
    chk("stall_write_count", 64'(writes), 64'd1);

    writes = 0;
    for (int i = 0; i < 2; i++)
      step(mk(0,1,1,1,1,2'b00,3'b000,5'd21,64'hCC,64'h0,64'h0, 0,5'd20,64'hAA,0,64'h1003,0), "stall_flush");
    chk("flush_write_count", 64'(writes), 64'd0);

    step(mk(0,1,0,0,1,2'b00,3'b000,5'd22,64'hBB,64'h0,64'h0, 1,5'd22,64'hBB,0,64'h1003,1), "pre_reset");
    step(mk(1,1,0,0,1,2'b00,3'b000,5'd23,64'hDD,64'h0,64'h0, 0,5'd0,64'h0,0,64'h0,0), "reset_after_accept");
    step(mk(0,1,0,0,1,2'b01,3'b010,5'd24,64'h2006,64'h0,64'h0, 0,5'd0,64'h0,1,64'h2006,0), "mis_before_reset");
    step(mk(1,1,1,1,1,2'b00,3'b000,5'd25,64'hEE,64'h0,64'h0, 0,5'd0,64'h0,0,64'h0,0), "reset_mid_stall");

`ifdef WB_INSTRET_EN
    chk("instret_reset", instret, 64'd0);
    for (int i = 0; i < 5; i++)
      step(mk(0,1,0,0,1,2'b00,3'b000,5'd26,64'(i),64'h0,64'h0, 1,5'd26,64'(i),0,64'h0,1), "retire");
    step(mk(0,0,0,0,0,2'b00,3'b000,5'd26,64'h0,64'h0,64'h0, 0,5'd26,64'd4,0,64'h0,0), "idle");
    chk("instret_count", instret, 64'd5);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
